// File: rtl/ara_cluster_sync_if.sv
// ara_cluster_sync_if: scalar-core and per-cluster request/response bundle
interface ara_cluster_sync_if #(
  parameter int unsigned NrClusters     = 4,
  parameter int unsigned ReqWidth       = 32,
  parameter int unsigned RespWidth      = 64,
  parameter int unsigned MaxOutstanding = 4
);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  logic                            req_valid_i;
  logic                            req_ready_o;
  logic [ReqWidth-1:0]             req_data_i;
  logic [NrClusters-1:0]           clu_req_valid_o;
  logic [NrClusters-1:0]           clu_req_ready_i;
  logic [ReqWidth-1:0]             clu_req_data_o;
  logic [NrClusters-1:0]           clu_resp_valid_i;
  logic [NrClusters-1:0]           clu_resp_ready_o;
  logic [NrClusters*RespWidth-1:0] clu_resp_data_i;
  logic [NrClusters-1:0]           clu_resp_error_i;
  logic                            resp_valid_o;
  logic                            resp_ready_i;
  logic [RespWidth-1:0]            resp_data_o;
  logic                            resp_error_o;
  logic                            mismatch_o;
  logic [CntW-1:0]                 outstanding_o;
  logic                            overflow_o;
  modport slave (
    input  req_valid_i, req_data_i, clu_req_ready_i, clu_resp_valid_i,
           clu_resp_data_i, clu_resp_error_i, resp_ready_i,
    output req_ready_o, clu_req_valid_o, clu_req_data_o, clu_resp_ready_o,
           resp_valid_o, resp_data_o, resp_error_o, mismatch_o,
           outstanding_o, overflow_o
  );
  modport master (
    output req_valid_i, req_data_i, clu_req_ready_i, clu_resp_valid_i,
           clu_resp_data_i, clu_resp_error_i, resp_ready_i,
    input  req_ready_o, clu_req_valid_o, clu_req_data_o, clu_resp_ready_o,
           resp_valid_o, resp_data_o, resp_error_o, mismatch_o,
           outstanding_o, overflow_o
  );
endinterface

// File: rtl/ara_cluster_sync.sv
// ara_cluster_sync: fork requests to all Ara clusters, join their responses, credit-limit in-flight work
module ara_cluster_sync #(
  parameter int unsigned NrClusters     = 4,
  parameter int unsigned ReqWidth       = 32,
  parameter int unsigned RespWidth      = 64,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned FifoDepth      = 4
) (
  input logic              clk_i,
  input logic              rst_ni,
  ara_cluster_sync_if.slave bus
);
  localparam int unsigned CW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned PW  = FifoDepth > 1 ? $clog2(FifoDepth) : 1;
  localparam int unsigned CNW = $clog2(FifoDepth + 1);
  if (NrClusters < 1) begin : g_bad_clusters
    $error("ara_cluster_sync: NrClusters must be at least 1");
  end
  if (MaxOutstanding < 1) begin : g_bad_outstanding
    $error("ara_cluster_sync: MaxOutstanding must be at least 1");
  end
  if (FifoDepth < MaxOutstanding) begin : g_bad_depth
    $error("ara_cluster_sync: FifoDepth must be at least MaxOutstanding");
  end
  logic [NrClusters-1:0] done_q, done_d, fire, full, empty, push, ovf;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic                  overflow_q, overflow_d;
  logic                  credit_ok, all_done, accept, pop, err, mm;
  logic [RespWidth:0]    head [NrClusters];
  assign credit_ok            = outstanding_q < CW'(MaxOutstanding);
  assign bus.clu_req_valid_o  = {NrClusters{bus.req_valid_i & credit_ok}} & ~done_q;
  assign fire                 = bus.clu_req_valid_o & bus.clu_req_ready_i;
  assign all_done             = &(done_q | fire);
  assign accept               = bus.req_valid_i & credit_ok & all_done;
  assign bus.req_ready_o      = accept;
  assign bus.clu_req_data_o   = bus.req_data_i;
  assign bus.clu_resp_ready_o = ~full;
  assign bus.resp_valid_o     = ~|empty;
  assign pop                  = bus.resp_valid_o & bus.resp_ready_i;
  assign bus.resp_data_o      = head[0][RespWidth-1:0];
  assign bus.resp_error_o     = err & bus.resp_valid_o;
  assign bus.mismatch_o       = mm & bus.resp_valid_o;
  assign bus.outstanding_o    = outstanding_q;
  assign bus.overflow_o       = overflow_q;
  for (genvar c = 0; c < NrClusters; c++) begin : g_fifo
    logic [RespWidth:0] mem_q [FifoDepth];
    logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [CNW-1:0]     cnt_q, cnt_d;
    assign full[c]  = cnt_q == CNW'(FifoDepth);
    assign empty[c] = cnt_q == '0;
    assign push[c]  = bus.clu_resp_valid_i[c] & ~full[c];
    assign head[c]  = mem_q[rd_q];
    // a response is unexpected when the FIFO already holds one entry per in-flight request
    assign ovf[c]   = bus.clu_resp_valid_i[c] & (full[c] | (int'(cnt_q) >= int'(outstanding_q)));
    // circular pointers and occupancy; simultaneous push and pop keep the count
    always_comb begin
      wr_d  = push[c] ? (wr_q == PW'(FifoDepth - 1) ? '0 : wr_q + 1'b1) : wr_q;
      rd_d  = pop ? (rd_q == PW'(FifoDepth - 1) ? '0 : rd_q + 1'b1) : rd_q;
      cnt_d = cnt_q + CNW'(push[c]) - CNW'(pop);
    end
    // pointer state
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        wr_q  <= wr_d;
        rd_q  <= rd_d;
        cnt_q <= cnt_d;
      end
    end
    // storage needs no reset: entries are only read once written
    always_ff @(posedge clk_i) begin
      if (push[c]) mem_q[wr_q] <= {bus.clu_resp_error_i[c], bus.clu_resp_data_i[c*RespWidth +: RespWidth]};
    end
  end
  // combine head error flags and compare every head against cluster 0
  always_comb begin
    err = 1'b0;
    mm  = 1'b0;
    for (int i = 0; i < NrClusters; i++) begin
      err = err | head[i][RespWidth];
      mm  = mm | (head[i][RespWidth-1:0] != head[0][RespWidth-1:0]);
    end
  end
  // fork bookkeeping, credit count and sticky protocol error
  always_comb begin
    done_d        = all_done ? '0 : done_q | fire;
    outstanding_d = outstanding_q + CW'(accept) - CW'(pop);
    overflow_d    = overflow_q | (|ovf);
  end
  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q        <= '0;
      outstanding_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      done_q        <= done_d;
      outstanding_q <= outstanding_d;
      overflow_q    <= overflow_d;
    end
  end
endmodule

// File: tb/tb_ara_cluster_sync.sv
// tb_ara_cluster_sync: directed stimulus with a response scoreboard for ara_cluster_sync
module tb_ara_cluster_sync;
  localparam int N = 4, RW = 32, SW = 64, MO = 4, FD = 4;
  typedef struct packed {
    logic          err;
    logic [SW-1:0] data;
    logic          mm;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q [$];
  always #5 clk = ~clk;
  ara_cluster_sync_if #(.NrClusters(N), .ReqWidth(RW), .RespWidth(SW), .MaxOutstanding(MO)) bus ();
  ara_cluster_sync #(.NrClusters(N), .ReqWidth(RW), .RespWidth(SW), .MaxOutstanding(MO), .FifoDepth(FD)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  task automatic resp(input logic [N-1:0] v, input logic [N-1:0] er,
                      input logic [SW-1:0] d0, input logic [SW-1:0] d1,
                      input logic [SW-1:0] d2, input logic [SW-1:0] d3);
    bus.clu_resp_valid_i = v;
    bus.clu_resp_error_i = er;
    bus.clu_resp_data_i  = {d3, d2, d1, d0};
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.resp_valid_o && bus.resp_ready_i) begin
      if (exp_q.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("resp_data", bus.resp_data_o, e.data);
        chk("resp_error", {63'd0, bus.resp_error_o}, {63'd0, e.err});
        chk("resp_mismatch", {63'd0, bus.mismatch_o}, {63'd0, e.mm});
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_data_i = '0;
    bus.clu_req_ready_i = '0;
    bus.resp_ready_i = 1'b0;
    resp('0, '0, '0, '0, '0, '0);
    #2;
    smp();
    chk("rst_resp_valid", bus.resp_valid_o, 0);
    chk("rst_clu_req_valid", bus.clu_req_valid_o, 0);
    chk("rst_req_ready", bus.req_ready_o, 0);
    chk("rst_clu_resp_ready", bus.clu_resp_ready_o, 4'hF);
    chk("rst_outstanding", bus.outstanding_o, 0);
    chk("rst_overflow", bus.overflow_o, 0);
    nxt();
    rst_n = 1'b1;
    nxt();
    bus.req_valid_i = 1'b1;
    bus.req_data_i = 32'hA5A5_0001;
    bus.clu_req_ready_i = 4'b0001;
    smp();
    chk("bcast_data", bus.clu_req_data_o, 32'hA5A5_0001);
    chk("skew_c1_valid", bus.clu_req_valid_o, 4'b1111);
    chk("skew_c1_ready", bus.req_ready_o, 0);
    nxt();
    bus.clu_req_ready_i = 4'b0100;
    smp();
    chk("skew_c2_valid", bus.clu_req_valid_o, 4'b1110);
    chk("skew_c2_ready", bus.req_ready_o, 0);
    nxt();
    bus.clu_req_ready_i = 4'b0010;
    smp();
    chk("skew_c3_valid", bus.clu_req_valid_o, 4'b1010);
    chk("skew_c3_ready", bus.req_ready_o, 0);
    nxt();
    bus.clu_req_ready_i = 4'b0000;
    smp();
    chk("skew_c4_valid", bus.clu_req_valid_o, 4'b1000);
    chk("skew_c4_ready", bus.req_ready_o, 0);
    nxt();
    bus.clu_req_ready_i = 4'b1000;
    smp();
    chk("skew_c5_valid", bus.clu_req_valid_o, 4'b1000);
    chk("skew_c5_ready", bus.req_ready_o, 1);
    nxt();
    bus.req_data_i = 32'hA5A5_0002;
    bus.clu_req_ready_i = 4'b0000;
    smp();
    chk("skew_done_cleared", bus.clu_req_valid_o, 4'b1111);
    chk("skew_outstanding", bus.outstanding_o, 1);
    nxt();
    bus.clu_req_ready_i = 4'b1111;
    smp();
    chk("second_req_ready", bus.req_ready_o, 1);
    nxt();
    bus.req_valid_i = 1'b0;
    bus.clu_req_ready_i = 4'b0000;
    smp();
    chk("two_outstanding", bus.outstanding_o, 2);
    chk("idle_clu_valid", bus.clu_req_valid_o, 0);
    exp_q.push_back('{err: 1'b0, data: 64'h11, mm: 1'b0});
    nxt();
    resp(4'b0001, '0, 64'h11, 64'h11, 64'h11, 64'h11);
    smp();
    chk("join_wait_c0", bus.resp_valid_o, 0);
    nxt(); resp('0, '0, '0, '0, '0, '0);
    nxt(); resp(4'b0010, '0, 64'h11, 64'h11, 64'h11, 64'h11);
    nxt(); resp('0, '0, '0, '0, '0, '0);
    nxt(); resp(4'b0100, '0, 64'h11, 64'h11, 64'h11, 64'h11);
    nxt(); resp('0, '0, '0, '0, '0, '0);
    nxt(); resp(4'b1000, '0, 64'h11, 64'h11, 64'h11, 64'h11);
    smp();
    chk("join_last_not_fallthrough", bus.resp_valid_o, 0);
    nxt();
    resp('0, '0, '0, '0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("hold_valid", bus.resp_valid_o, 1);
      chk("hold_data", bus.resp_data_o, 64'h11);
      chk("hold_mismatch", bus.mismatch_o, 0);
      nxt();
    end
    bus.resp_ready_i = 1'b1;
    smp();
    nxt();
    bus.resp_ready_i = 1'b0;
    smp();
    chk("join_popped_valid", bus.resp_valid_o, 0);
    chk("join_outstanding", bus.outstanding_o, 1);
    exp_q.push_back('{err: 1'b1, data: 64'h11, mm: 1'b1});
    nxt();
    resp(4'b1111, 4'b0100, 64'h11, 64'h11, 64'h22, 64'h11);
    nxt();
    resp('0, '0, '0, '0, '0, '0);
    bus.resp_ready_i = 1'b1;
    smp();
    chk("errmm_error", bus.resp_error_o, 1);
    chk("errmm_mismatch", bus.mismatch_o, 1);
    nxt();
    bus.resp_ready_i = 1'b0;
    smp();
    chk("errmm_outstanding", bus.outstanding_o, 0);
    nxt();
    bus.req_valid_i = 1'b1;
    bus.clu_req_ready_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      bus.req_data_i = 32'h100 + 32'(i);
      smp();
      chk("credit_ready", bus.req_ready_o, (i < 4) ? 1 : 0);
      if (i < 4) nxt();
    end
    chk("credit_outstanding", bus.outstanding_o, 4);
    chk("credit_clu_valid", bus.clu_req_valid_o, 0);
    exp_q.push_back('{err: 1'b0, data: 64'h33, mm: 1'b0});
    nxt();
    resp(4'b1111, '0, 64'h33, 64'h33, 64'h33, 64'h33);
    smp();
    chk("credit_full_ready", bus.req_ready_o, 0);
    nxt();
    resp('0, '0, '0, '0, '0, '0);
    bus.resp_ready_i = 1'b1;
    smp();
    chk("credit_pop_same_cycle", bus.req_ready_o, 0);
    nxt();
    bus.resp_ready_i = 1'b0;
    smp();
    chk("credit_after_pop_cnt", bus.outstanding_o, 3);
    chk("credit_after_pop_ready", bus.req_ready_o, 1);
    nxt();
    bus.req_valid_i = 1'b0;
    bus.clu_req_ready_i = 4'b0000;
    smp();
    chk("credit_refilled", bus.outstanding_o, 4);
    bus.resp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      resp(4'b1111, '0, 64'h40 + 64'(i), 64'h40 + 64'(i), 64'h40 + 64'(i), 64'h40 + 64'(i));
      exp_q.push_back('{err: 1'b0, data: 64'h40 + 64'(i), mm: 1'b0});
    end
    nxt();
    resp('0, '0, '0, '0, '0, '0);
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) nxt();
    chk("drain_empty", 64'(exp_q.size()), 0);
    bus.resp_ready_i = 1'b0;
    smp();
    chk("drain_outstanding", bus.outstanding_o, 0);
    chk("drain_no_overflow", bus.overflow_o, 0);
    chk("drain_resp_valid", bus.resp_valid_o, 0);
    nxt();
    resp(4'b0010, '0, '0, 64'h55, '0, '0);
    smp();
    chk("ovf_same_cycle", bus.overflow_o, 0);
    nxt();
    resp('0, '0, '0, '0, '0, '0);
    smp();
    chk("ovf_set", bus.overflow_o, 1);
    repeat (3) nxt();
    smp();
    chk("ovf_sticky", bus.overflow_o, 1);
    nxt();
    bus.req_valid_i = 1'b1;
    bus.clu_req_ready_i = 4'b1111;
    bus.req_data_i = 32'h200;
    smp();
    chk("mid_req1", bus.req_ready_o, 1);
    nxt();
    bus.req_data_i = 32'h201;
    smp();
    chk("mid_req2", bus.req_ready_o, 1);
    nxt();
    bus.req_data_i = 32'h202;
    bus.clu_req_ready_i = 4'b0011;
    smp();
    chk("mid_req3_blocked", bus.req_ready_o, 0);
    nxt();
    bus.clu_req_ready_i = 4'b0000;
    smp();
    chk("mid_partial_done", bus.clu_req_valid_o, 4'b1100);
    chk("mid_outstanding", bus.outstanding_o, 2);
    #2;
    rst_n = 1'b0;
    bus.req_valid_i = 1'b0;
    #1;
    chk("arst_resp_valid", bus.resp_valid_o, 0);
    chk("arst_outstanding", bus.outstanding_o, 0);
    chk("arst_clu_req_valid", bus.clu_req_valid_o, 0);
    chk("arst_overflow", bus.overflow_o, 0);
    chk("arst_clu_resp_ready", bus.clu_resp_ready_o, 4'hF);
    nxt();
    nxt();
    rst_n = 1'b1;
    nxt();
    bus.req_valid_i = 1'b1;
    bus.req_data_i = 32'h300;
    smp();
    chk("post_rst_fork", bus.clu_req_valid_o, 4'b1111);
    nxt();
    bus.clu_req_ready_i = 4'b1111;
    smp();
    chk("post_rst_ready", bus.req_ready_o, 1);
    nxt();
    bus.req_valid_i = 1'b0;
    bus.clu_req_ready_i = 4'b0000;
    smp();
    chk("post_rst_outstanding", bus.outstanding_o, 1);
    chk("final_queue_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
